// File: rtl/posit_divider_8bit_seq_if.sv
// Handshake bundle for the 8-bit posit (es=0) sequential divider.
// The master side presents operands and consumes the quotient; the slave side is the divider.
interface posit_divider_8bit_seq_if;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] dividend;
    logic [7:0] divisor;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] quotient;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient
    );
endinterface

// File: rtl/posit_divider_8bit_seq.sv
// Sequential 8-bit posit (es=0) divider: restoring fraction division, round to nearest even.
// Fixed 10-edge latency from acceptance to out_valid, specials included.
//
// state  | meaning
// IDLE   | in_ready=1, waiting for an operand pair
// DIVIDE | one restoring quotient bit per cycle, counter 0..7
// ROUND  | cnt=0: form truncated code, guard, sticky; cnt=1: round and publish
// DONE   | out_valid=1, quotient held until out_ready
module posit_divider_8bit_seq (
    input  logic                      clk,
    input  logic                      rst_n,
    posit_divider_8bit_seq_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

    state_t             r_state;
    logic [2:0]         r_cnt;
    logic [6:0]         r_rem;
    logic [5:0]         r_div;
    logic [7:0]         r_q;
    logic signed [5:0]  r_exp;
    logic               r_sign;
    logic               r_nar;
    logic               r_zero;
    logic [6:0]         r_trunc;
    logic               r_guard;
    logic               r_sticky;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [7:0]         r_quot;

    // Length of the leading run of identical bits (the regime), at least 1.
    function automatic logic [3:0] f_run(input logic [6:0] body);
        logic [3:0] n;
        logic       stop;
        n    = 4'd0;
        stop = 1'b0;
        for (int i = 6; i >= 0; i--) begin
            if (!stop && (body[i] == body[6])) n = n + 4'd1;
            else stop = 1'b1;
        end
        return n;
    endfunction

    // Operand decode: magnitude body, regime run, scale, hidden bit + 5-bit fraction.
    logic [6:0]        w_body_a, w_body_b;
    logic [3:0]        w_run_a, w_run_b;
    logic signed [5:0] w_exp_a, w_exp_b, w_exp_q;
    logic [5:0]        w_mant_a, w_mant_b;
    logic              w_nar, w_zero;

    assign w_body_a = bus.dividend[7] ? (~bus.dividend[6:0] + 7'd1) : bus.dividend[6:0];
    assign w_body_b = bus.divisor[7]  ? (~bus.divisor[6:0]  + 7'd1) : bus.divisor[6:0];
    assign w_run_a  = f_run(w_body_a);
    assign w_run_b  = f_run(w_body_b);
    assign w_exp_a  = w_body_a[6] ? (6'(w_run_a) - 6'd1) : (6'd0 - 6'(w_run_a));
    assign w_exp_b  = w_body_b[6] ? (6'(w_run_b) - 6'd1) : (6'd0 - 6'(w_run_b));
    // Fraction bits sit below the regime and its terminator; left-align them to 5 bits.
    assign w_mant_a = {1'b1, 5'(w_body_a << (w_run_a - 4'd1))};
    assign w_mant_b = {1'b1, 5'(w_body_b << (w_run_b - 4'd1))};
    // A smaller dividend fraction gives a quotient below 1.0, so one extra normalising step down.
    assign w_exp_q  = w_exp_a - w_exp_b - 6'(w_mant_a < w_mant_b);
    assign w_nar    = (bus.dividend == 8'h80) || (bus.divisor == 8'h80) || (bus.divisor == 8'h00);
    assign w_zero   = (bus.dividend == 8'h00);

    // Restoring division step.
    logic       w_ge;
    logic [6:0] w_rem_sub;
    assign w_ge      = (r_rem >= {1'b0, r_div});
    assign w_rem_sub = w_ge ? (r_rem - {1'b0, r_div}) : r_rem;

    // Encode: place regime then fraction, cut at 7 bits, derive guard and sticky, saturate out of range.
    logic [6:0]  w_frac7;
    logic [22:0] w_regime, w_seq;
    logic [3:0]  w_rlen;
    logic [6:0]  w_trunc;
    logic        w_guard, w_sticky;
    always_comb begin
        w_frac7 = r_q[7] ? r_q[6:0] : {r_q[5:0], 1'b0};
        if (r_exp >= 6'sd0) begin
            w_regime = ~(23'h7FFFFF >> (r_exp[3:0] + 4'd1));
            w_rlen   = r_exp[3:0] + 4'd2;
        end else begin
            w_regime = 23'h400000 >> 4'(-r_exp);
            w_rlen   = 4'(-r_exp) + 4'd1;
        end
        w_seq    = w_regime | ({w_frac7, 16'b0} >> w_rlen);
        w_trunc  = w_seq[22:16];
        w_guard  = w_seq[15];
        w_sticky = (|w_seq[14:0]) | (|r_rem);
        if (r_exp > 6'sd6) begin
            w_trunc  = 7'h7F;
            w_guard  = 1'b0;
            w_sticky = 1'b0;
        end else if (r_exp < -6'sd6) begin
            w_trunc  = 7'h01;
            w_guard  = 1'b0;
            w_sticky = 1'b0;
        end
    end

    // Round to nearest even; the truncated code is never 0 and e=6 has guard 0, so no wrap.
    logic       w_round_up;
    logic [6:0] w_mag;
    logic [7:0] w_quot;
    assign w_round_up = r_guard & (r_sticky | r_trunc[0]);
    assign w_mag      = r_trunc + 7'(w_round_up);
    assign w_quot     = r_nar  ? 8'h80 :
                        r_zero ? 8'h00 :
                        r_sign ? (8'd0 - {1'b0, w_mag}) : {1'b0, w_mag};

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.quotient  = r_quot;

    // Control FSM with registered handshake outputs and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= 3'd0;
            r_rem       <= 7'd0;
            r_div       <= 6'd0;
            r_q         <= 8'd0;
            r_exp       <= 6'sd0;
            r_sign      <= 1'b0;
            r_nar       <= 1'b0;
            r_zero      <= 1'b0;
            r_trunc     <= 7'd0;
            r_guard     <= 1'b0;
            r_sticky    <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_quot      <= 8'h00;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_rem      <= {1'b0, w_mant_a};
                        r_div      <= w_mant_b;
                        r_exp      <= w_exp_q;
                        r_sign     <= bus.dividend[7] ^ bus.divisor[7];
                        r_nar      <= w_nar;
                        r_zero     <= w_zero;
                        r_q        <= 8'd0;
                        r_cnt      <= 3'd0;
                        r_in_ready <= 1'b0;
                        r_state    <= DIVIDE;
                    end
                end
                DIVIDE: begin
                    r_rem <= w_rem_sub << 1;
                    r_q   <= {r_q[6:0], w_ge};
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) r_state <= ROUND;
                end
                ROUND: begin
                    if (r_cnt == 3'd0) begin
                        r_trunc  <= w_trunc;
                        r_guard  <= w_guard;
                        r_sticky <= w_sticky;
                        r_cnt    <= 3'd1;
                    end else begin
                        r_quot      <= w_quot;
                        r_out_valid <= 1'b1;
                        r_cnt       <= 3'd0;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_posit_divider_8bit_seq.sv
// Self-checking bench for posit_divider_8bit_seq: directed corner cases plus random operands
// against a value-domain reference (exact rational quotient rounded to the nearest posit).
module tb_posit_divider_8bit_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_errs   = 0;

    posit_divider_8bit_seq_if bus();

    posit_divider_8bit_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Value of a positive posit code (1..127) scaled by 2^11, so every posit is an integer.
    function automatic longint posit_val(input logic [6:0] code);
        int     run;
        int     k;
        int     nf;
        bit     stop;
        longint f;
        run  = 0;
        stop = 0;
        for (int i = 6; i >= 0; i--) begin
            if (!stop && code[i] == code[6]) run++;
            else stop = 1;
        end
        k  = code[6] ? run - 1 : -run;
        nf = 6 - run;
        if (nf < 0) nf = 0;
        f = longint'(code) & ((longint'(1) << nf) - 1);
        return (((longint'(1) << nf) + f) << (k + 11)) >> nf;
    endfunction

    // Reference: exact quotient, nearest posit by value, ties to the even code, clamp to min/maxpos.
    function automatic logic [7:0] ref_div(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] ma, mb, r;
        longint     va, vb, lhs, rhs;
        int         c;
        if (a == 8'h80 || b == 8'h80 || b == 8'h00) return 8'h80;
        if (a == 8'h00) return 8'h00;
        ma = a[7] ? 8'(-a) : a;
        mb = b[7] ? 8'(-b) : b;
        va = posit_val(ma[6:0]);
        vb = posit_val(mb[6:0]);
        c  = 0;
        for (int i = 1; i < 128; i++)
            if (posit_val(7'(i)) * vb <= va * 2048) c = i;
        if (c == 0) r = 8'h01;
        else if (c == 127) r = 8'h7F;
        else begin
            lhs = 2 * va * 2048;
            rhs = (posit_val(7'(c)) + posit_val(7'(c + 1))) * vb;
            if (lhs < rhs) r = 8'(c);
            else if (lhs > rhs) r = 8'(c + 1);
            else r = (c % 2 == 0) ? 8'(c) : 8'(c + 1);
        end
        return (a[7] ^ b[7]) ? 8'(-r) : r;
    endfunction

    // One transaction: accept, scramble inputs while busy, check latency/result, hold, release.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_q,
                          input int hold, input string tag);
        int n;
        check_val({tag, "/in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.dividend = a;
        bus.divisor  = b;
        @(posedge clk); #1;
        n = 0;
        while (n < 20) begin
            bus.in_valid  = 1'($urandom);
            bus.dividend  = 8'($urandom);
            bus.divisor   = 8'($urandom);
            bus.out_ready = 1'($urandom);
            @(posedge clk); n++; #1;
            if (bus.out_valid) break;
        end
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        check_val({tag, "/latency"}, 32'(n), 32'd10);
        check_val({tag, "/quotient"}, 32'(bus.quotient), 32'(exp_q));
        check_val({tag, "/in_ready_busy"}, 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_val({tag, "/hold_valid"}, 32'(bus.out_valid), 32'd1);
            check_val({tag, "/hold_quot"}, 32'(bus.quotient), 32'(exp_q));
            check_val({tag, "/hold_ready"}, 32'(bus.in_ready), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check_val({tag, "/valid_drop"}, 32'(bus.out_valid), 32'd0);
        check_val({tag, "/ready_rise"}, 32'(bus.in_ready), 32'd1);
        check_val({tag, "/retain"}, 32'(bus.quotient), 32'(exp_q));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] a, b;
        bit         seen;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = 8'h00;
        bus.divisor   = 8'h00;
        rst_n = 1'b0;
        #7;
        check_val("rst/in_ready", 32'(bus.in_ready), 32'd1);
        check_val("rst/out_valid", 32'(bus.out_valid), 32'd0);
        check_val("rst/quotient", 32'(bus.quotient), 32'h00);
        #5 rst_n = 1'b1;

        run_op(8'h40, 8'h68, 8'h15, 0, "one_third");
        run_op(8'h70, 8'h60, 8'h60, 0, "four_by_two");
        run_op(8'h7F, 8'h01, 8'h7F, 0, "sat_max");
        run_op(8'h01, 8'h7F, 8'h01, 0, "sat_min");
        run_op(8'h40, 8'h00, 8'h80, 0, "div_zero");
        run_op(8'h80, 8'h40, 8'h80, 0, "nar_in");
        run_op(8'h00, 8'h20, 8'h00, 0, "zero_num");
        run_op(8'h00, 8'h00, 8'h80, 0, "zero_zero");
        run_op(8'h40, 8'h68, 8'h15, 5, "hold");
        run_op(8'h60, 8'hC0, 8'hA0, 0, "neg");

        bus.dividend = 8'h40;
        bus.divisor  = 8'h68;
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_val("midrst/in_ready", 32'(bus.in_ready), 32'd1);
        check_val("midrst/out_valid", 32'(bus.out_valid), 32'd0);
        check_val("midrst/quotient", 32'(bus.quotient), 32'h00);
        #2 rst_n = 1'b1;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (bus.out_valid) seen = 1;
        end
        check_val("midrst/no_spurious", 32'(seen), 32'd0);
        run_op(8'h40, 8'h68, 8'h15, 0, "after_rst");

        for (int i = 0; i < 60; i++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if ($urandom_range(0, 15) == 0) b = 8'h00;
            if ($urandom_range(0, 15) == 0) a = 8'h80;
            run_op(a, b, ref_div(a, b), int'($urandom_range(0, 2)), "rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end
endmodule

// File: doc/posit_divider_8bit_seq.md
POSIT_DIVIDER_8BIT_SEQ -- requirements
Module: posit_divider_8bit_seq

Interface
REQ-001 The block SHALL have no parameters; the format is fixed at 8-bit posit, es=0.
REQ-002 The block SHALL have one clock; reset SHALL be asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  operand pair is presented.
REQ-006 in_ready  output  1  block accepts operands this cycle.
REQ-007 dividend  input  8  posit numerator.
REQ-008 divisor  input  8  posit denominator.
REQ-009 out_valid  output  1  quotient is valid.
REQ-010 out_ready  input  1  consumer takes the quotient.
REQ-011 quotient  output  8  posit result, dividend/divisor.

Function
REQ-012 The FSM SHALL have states IDLE, DIVIDE, ROUND and DONE.
REQ-013 in_ready SHALL equal 1 only in IDLE.
REQ-014 Acceptance SHALL occur on a clock edge where in_valid=1 and in_ready=1.
REQ-015 On acceptance the block SHALL register both operands, decode them to sign/exponent/hidden+5-bit fraction, and enter DIVIDE.
REQ-016 DIVIDE SHALL run a restoring fraction division producing one quotient bit per cycle for exactly 8 cycles (counter 0..7), then enter ROUND.
REQ-017 Quotient exponent SHALL be exp_dividend - exp_divisor, minus 1 when the dividend fraction is less than the divisor fraction (normalisation).
REQ-018 Quotient sign SHALL be the XOR of the operand signs.
REQ-019 ROUND SHALL form guard plus sticky (sticky = OR of any remaining-remainder nonzero and lower quotient bits), encode, and round to nearest even, then enter DONE.
REQ-020 Magnitude SHALL saturate at maxpos (0x7F) and minpos (0x01); a nonzero finite result SHALL never encode as 0x00 or 0x80.
REQ-021 If either operand is NaR (0x80) or divisor=0x00, quotient SHALL be 0x80.
REQ-022 Otherwise, if dividend=0x00, quotient SHALL be 0x00.
REQ-023 Special cases SHALL use the same FSM path and latency as normal operands.
REQ-024 Latency SHALL be fixed: out_valid rises on the 10th rising edge after the acceptance edge.
REQ-025 In DONE, out_valid SHALL be 1 and quotient SHALL be held stable until out_ready=1.
REQ-026 On a DONE edge with out_ready=1 the block SHALL go to IDLE; out_valid SHALL deassert, and in_ready SHALL rise, in the following cycle.
REQ-027 There SHALL be no same-cycle pass-through from the output handshake to in_ready.
REQ-028 in_valid and operand changes while not in IDLE SHALL be ignored.
REQ-029 out_ready while not in DONE SHALL be ignored.
REQ-030 quotient SHALL update only on the ROUND-to-DONE transition and retain its value in IDLE.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, quotient=0x00, and clear the counter and remainder, regardless of clk.
REQ-032 Reset asserted mid-DIVIDE or in DONE SHALL discard the operation; no out_valid SHALL appear for it after release.
REQ-033 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-034 dividend=0x40 (1.0), divisor=0x68 (3.0) -> quotient=0x15 (1/3 rounded), out_valid exactly 10 edges after accept.
REQ-035 0x60 (2.0) / 0xC0 (-1.0) -> 0xA0 (-2.0); 0x70 (4.0) / 0x60 -> 0x60.
REQ-036 0x7F / 0x01 -> 0x7F (saturate); 0x01 / 0x7F -> 0x01 (no underflow to zero).
REQ-037 0x40 / 0x00 -> 0x80; 0x80 / 0x40 -> 0x80; 0x00 / 0x20 -> 0x00; all with the same 10-edge latency.
REQ-038 Hold out_ready=0 for 5 cycles in DONE -> quotient/out_valid stable, in_ready=0, and a new in_valid is ignored; release -> the next accept occurs no earlier than 1 cycle later.
REQ-039 Pulse rst_n low at DIVIDE counter=4 -> outputs immediately at reset values; no spurious out_valid; the next operation is correct.
